div_clk_monitor: RTL and testbench

- Receive-side checker for an integer-divided clock, e.g. the 50%-duty divide-by-9 output of the team's clock divider.
- Samples the divided signal in the fast `clk` domain and measures its period and high time in `clk` cycles.
- Declares lock after a run of correct periods; flags period, duty and stall faults.
- Sits beside the divider in the clocking test harness and on-chip self-check path.

---
 rtl/div_clk_monitor.sv | 235 +++++++++++++++++++++++
 tb/tb_div_clk_monitor.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_clk_monitor.sv
// div_clk_monitor
// Receive-side checker for an integer-divided clock. It samples sig_in in the
// clk domain and measures the rise-to-rise period and the high time in clk
// cycles. It declares lock after LOCK_CNT consecutive periods of exactly DIV
// cycles, and it pulses period, duty and stall faults.
// Optional feature macro: DIV_CLK_MONITOR_DUTY_CHECK_EN. When it is defined,
// the high-time counter and the fall capture logic are built. When it is not
// defined, high_width and duty_err are tied to 0. The ports and the
// period/lock behaviour are the same in both builds.
module div_clk_monitor #(
  parameter int DIV      = 9,
  parameter int LOCK_CNT = 4,
  parameter int CW       = $clog2(2*DIV+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sig_in,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_width,
  output logic          meas_valid,
  output logic          lock,
  output logic          period_err,
  output logic          duty_err,
  output logic          stall_err
);

  localparam int GW = $clog2(LOCK_CNT+1);
  localparam logic [CW-1:0] DIV_C  = CW'(DIV);
  localparam logic [CW-1:0] PMAX_C = CW'(2*DIV);
  localparam logic [GW-1:0] LOCK_C = GW'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Input path: two-flop synchronizer followed by one delay stage.
  // ---------------------------------------------------------------------------
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic s_dly_q, s_dly_d;
  logic s;
  logic rise;

  // The synchronizer and delay chain simply shift sig_in toward the clk domain.
  always_comb begin
    sync1_d = sig_in;
    sync2_d = sync1_q;
    s_dly_d = sync2_q;
  end

  // Registers for the synchronizer and delay chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      s_dly_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      s_dly_q <= s_dly_d;
    end
  end

  assign s    = sync2_q;
  assign rise = s & ~s_dly_q;

  // ---------------------------------------------------------------------------
  // Period counter: restarts at 1 after every rise and saturates at 2*DIV.
  // The saturation value also serves as the stall threshold.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] pcnt_q, pcnt_d;

  // Reload on a rise, otherwise count up until the stall threshold.
  always_comb begin
    pcnt_d = pcnt_q;
    if (rise) begin
      pcnt_d = CW'(1);
    end else if (pcnt_q != PMAX_C) begin
      pcnt_d = pcnt_q + CW'(1);
    end
  end

  // Register for the period counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock FSM with registered outputs.
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic [GW-1:0] good_inc;
  logic [CW-1:0] period_q, period_d;
  logic          meas_valid_q, meas_valid_d;
  logic          lock_q, lock_d;
  logic          period_err_q, period_err_d;
  logic          stall_err_q, stall_err_d;

  // Next-state logic. A rise takes priority over stall detection, so a rise
  // that arrives exactly when the counter saturates is measured and is not
  // treated as a stall.
  always_comb begin
    state_d      = state_q;
    good_cnt_d   = good_cnt_q;
    period_d     = period_q;
    lock_d       = lock_q;
    meas_valid_d = 1'b0;
    period_err_d = 1'b0;
    stall_err_d  = 1'b0;
    good_inc     = (good_cnt_q == LOCK_C) ? good_cnt_q : good_cnt_q + GW'(1);
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MEASURE;
        end
      end
      MEASURE, LOCKED: begin
        if (rise) begin
          period_d     = pcnt_q;
          meas_valid_d = 1'b1;
          if (pcnt_q == DIV_C) begin
            good_cnt_d = good_inc;
            if (good_inc == LOCK_C) begin
              state_d = LOCKED;
              lock_d  = 1'b1;
            end
          end else begin
            period_err_d = 1'b1;
            good_cnt_d   = '0;
            lock_d       = 1'b0;
            state_d      = MEASURE;
          end
        end else if (pcnt_q == PMAX_C) begin
          stall_err_d = 1'b1;
          good_cnt_d  = '0;
          lock_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        good_cnt_d = '0;
        lock_d     = 1'b0;
      end
    endcase
  end

  // Single register stage for the FSM state and its registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      good_cnt_q   <= '0;
      period_q     <= '0;
      meas_valid_q <= 1'b0;
      lock_q       <= 1'b0;
      period_err_q <= 1'b0;
      stall_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      good_cnt_q   <= good_cnt_d;
      period_q     <= period_d;
      meas_valid_q <= meas_valid_d;
      lock_q       <= lock_d;
      period_err_q <= period_err_d;
      stall_err_q  <= stall_err_d;
    end
  end

  assign period     = period_q;
  assign meas_valid = meas_valid_q;
  assign lock       = lock_q;
  assign period_err = period_err_q;
  assign stall_err  = stall_err_q;

`ifdef DIV_CLK_MONITOR_DUTY_CHECK_EN
  // ---------------------------------------------------------------------------
  // Duty measurement: count high cycles from each rise and capture the count
  // on the following fall. Only the values DIV/2 and (DIV+1)/2 are legal.
  // ---------------------------------------------------------------------------
  localparam logic [CW-1:0] HLO_C = CW'(DIV/2);
  localparam logic [CW-1:0] HHI_C = CW'((DIV+1)/2);

  logic          fall;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] high_width_q, high_width_d;
  logic          duty_err_q, duty_err_d;

  assign fall = ~s & s_dly_q;

  // The high counter restarts on a rise and counts while the synchronized
  // signal stays high. A fall seen while no measurement is active is ignored.
  always_comb begin
    hcnt_d       = hcnt_q;
    high_width_d = high_width_q;
    duty_err_d   = 1'b0;
    if (rise) begin
      hcnt_d = CW'(1);
    end else if (s && (hcnt_q != PMAX_C)) begin
      hcnt_d = hcnt_q + CW'(1);
    end
    if (fall && (state_q != IDLE)) begin
      high_width_d = hcnt_q;
      duty_err_d   = (hcnt_q != HLO_C) && (hcnt_q != HHI_C);
    end
  end

  // Registers for the duty measurement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt_q       <= '0;
      high_width_q <= '0;
      duty_err_q   <= 1'b0;
    end else begin
      hcnt_q       <= hcnt_d;
      high_width_q <= high_width_d;
      duty_err_q   <= duty_err_d;
    end
  end

  assign high_width = high_width_q;
  assign duty_err   = duty_err_q;
`else
  assign high_width = '0;
  assign duty_err   = 1'b0;
`endif

endmodule

// File: tb/tb_div_clk_monitor.sv
// tb_div_clk_monitor
// Drives two monitors: a DIV=9/LOCK_CNT=4 instance and a DIV=4/LOCK_CNT=1
// instance. Each one receives a waveform built from per-period high/low
// lengths. A reference model predicts every output from the edge times of the
// driven waveform. It uses a fixed three-cycle observation latency, which
// comes from the two synchronizer stages plus the registered outputs.
module tb_div_clk_monitor;

  localparam int DIV0 = 9;
  localparam int LC0  = 4;
  localparam int DIV1 = 4;
  localparam int LC1  = 1;
  localparam int CW0  = $clog2(2*DIV0+1);
  localparam int CW1  = $clog2(2*DIV1+1);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic sig0  = 1'b0;
  logic sig1  = 1'b0;

  logic [CW0-1:0] period0, high_width0;
  logic           meas_valid0, lock0, period_err0, duty_err0, stall_err0;
  logic [CW1-1:0] period1, high_width1;
  logic           meas_valid1, lock1, period_err1, duty_err1, stall_err1;

  // Free-running reference clock.
  always #5 clk = ~clk;

  div_clk_monitor #(.DIV(DIV0), .LOCK_CNT(LC0)) dut0 (
    .clk(clk), .reset(reset), .sig_in(sig0),
    .period(period0), .high_width(high_width0), .meas_valid(meas_valid0),
    .lock(lock0), .period_err(period_err0), .duty_err(duty_err0),
    .stall_err(stall_err0)
  );

  div_clk_monitor #(.DIV(DIV1), .LOCK_CNT(LC1)) dut1 (
    .clk(clk), .reset(reset), .sig_in(sig1),
    .period(period1), .high_width(high_width1), .meas_valid(meas_valid1),
    .lock(lock1), .period_err(period_err1), .duty_err(duty_err1),
    .stall_err(stall_err1)
  );

  typedef struct {
    int period;
    int high_width;
    int meas_valid;
    int lock;
    int period_err;
    int duty_err;
    int stall_err;
  } snap_t;

  snap_t exp0[$];
  snap_t exp1[$];
  bit    wave0[$];
  bit    wave1[$];

  // Model state per instance: the time of the last rise, whether a
  // measurement is running, and the current run of good periods.
  int    m_div[2];
  int    m_lock_cnt[2];
  bit    m_active[2];
  int    m_good[2];
  bit    m_prev[2];
  int    m_last_rise[2];
  snap_t m_hold[2];

  int checks      = 0;
  int failures    = 0;
  int cyc         = 0;
  bit rel_pending = 1'b0;
  bit hi5_next    = 1'b0;

  function automatic snap_t zero_snap();
    snap_t z;
    z.period = 0; z.high_width = 0; z.meas_valid = 0; z.lock = 0;
    z.period_err = 0; z.duty_err = 0; z.stall_err = 0;
    return z;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, observed, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_active[i]    = 1'b0;
      m_good[i]      = 0;
      m_prev[i]      = 1'b0;
      m_last_rise[i] = -1000;
      m_hold[i]      = zero_snap();
    end
    exp0.delete();
    exp1.delete();
    for (int k = 0; k < 3; k++) begin
      exp0.push_back(zero_snap());
      exp1.push_back(zero_snap());
    end
  endtask

  // Predict the outputs three cycles after sig_in takes value v at time t.
  task automatic model_step(input int i, input int t, input bit v, output snap_t o);
    bit was_active;
    bit rise;
    bit fall;
    int d;
    int w;
    was_active = m_active[i];
    rise = v && !m_prev[i];
    fall = !v && m_prev[i];
    d = t - m_last_rise[i];
    o = m_hold[i];
    o.meas_valid = 0; o.period_err = 0; o.duty_err = 0; o.stall_err = 0;
    if (rise) begin
      if (m_active[i]) begin
        o.period = d;
        o.meas_valid = 1;
        if (d == m_div[i]) begin
          if (m_good[i] < m_lock_cnt[i]) m_good[i]++;
          if (m_good[i] == m_lock_cnt[i]) o.lock = 1;
        end else begin
          o.period_err = 1;
          m_good[i] = 0;
          o.lock = 0;
        end
      end
      m_active[i] = 1'b1;
      m_last_rise[i] = t;
    end else if (m_active[i] && d == 2*m_div[i]) begin
      o.stall_err = 1;
      m_active[i] = 1'b0;
      m_good[i] = 0;
      o.lock = 0;
    end
`ifdef DIV_CLK_MONITOR_DUTY_CHECK_EN
    if (fall && was_active) begin
      w = (d > 2*m_div[i]) ? 2*m_div[i] : d;
      o.high_width = w;
      o.duty_err = ((w == m_div[i]/2) || (w == (m_div[i]+1)/2)) ? 0 : 1;
    end
`else
    w = 0;
    if (fall && was_active) o.high_width = w;
`endif
    m_prev[i] = v;
    m_hold[i] = o;
  endtask

  task automatic addPeriod(input int i, input int hi, input int lo);
    for (int k = 0; k < hi + lo; k++) begin
      if (i == 0) wave0.push_back(k < hi);
      else        wave1.push_back(k < hi);
    end
  endtask

  task automatic addIdeal(input int i);
    int hi;
    if (i == 0) begin
      hi = hi5_next ? 5 : 4;
      hi5_next = !hi5_next;
      addPeriod(0, hi, DIV0 - hi);
    end else begin
      addPeriod(1, 2, 2);
    end
  endtask

  task automatic checkCycle();
    snap_t e0, e1;
    e0 = exp0.pop_front();
    e1 = exp1.pop_front();
    checkOutput("i0_period",     int'(period0),     e0.period);
    checkOutput("i0_high_width", int'(high_width0), e0.high_width);
    checkOutput("i0_meas_valid", int'(meas_valid0), e0.meas_valid);
    checkOutput("i0_lock",       int'(lock0),       e0.lock);
    checkOutput("i0_period_err", int'(period_err0), e0.period_err);
    checkOutput("i0_duty_err",   int'(duty_err0),   e0.duty_err);
    checkOutput("i0_stall_err",  int'(stall_err0),  e0.stall_err);
    checkOutput("i1_period",     int'(period1),     e1.period);
    checkOutput("i1_high_width", int'(high_width1), e1.high_width);
    checkOutput("i1_meas_valid", int'(meas_valid1), e1.meas_valid);
    checkOutput("i1_lock",       int'(lock1),       e1.lock);
    checkOutput("i1_period_err", int'(period_err1), e1.period_err);
    checkOutput("i1_duty_err",   int'(duty_err1),   e1.duty_err);
    checkOutput("i1_stall_err",  int'(stall_err1),  e1.stall_err);
  endtask

  task automatic applyStimulus(input int n);
    snap_t s0, s1;
    bit v0, v1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      checkCycle();
      if (rel_pending) begin
        reset = 1'b1;
        rel_pending = 1'b0;
      end
      if (wave0.size() == 0) addIdeal(0);
      if (wave1.size() == 0) addIdeal(1);
      v0 = wave0.pop_front();
      v1 = wave1.pop_front();
      sig0 = v0;
      sig1 = v1;
      model_step(0, cyc, v0, s0);
      exp0.push_back(s0);
      model_step(1, cyc, v1, s1);
      exp1.push_back(s1);
      cyc++;
    end
  endtask

  // Assert reset asynchronously in mid-cycle and check that every output
  // clears at once. Reset is released at the next stimulus step.
  task automatic do_reset();
    #3;
    reset = 1'b0;
    #1;
    checkOutput("rst_i0_period",     int'(period0),     0);
    checkOutput("rst_i0_high_width", int'(high_width0), 0);
    checkOutput("rst_i0_meas_valid", int'(meas_valid0), 0);
    checkOutput("rst_i0_lock",       int'(lock0),       0);
    checkOutput("rst_i0_errors",     int'({period_err0, duty_err0, stall_err0}), 0);
    checkOutput("rst_i1_period",     int'(period1),     0);
    checkOutput("rst_i1_lock",       int'(lock1),       0);
    checkOutput("rst_i1_errors",     int'({meas_valid1, period_err1, duty_err1, stall_err1}), 0);
    model_reset();
    rel_pending = 1'b1;
  endtask

  initial begin
    int per;
    int hi;
    int n;
    m_div[0] = DIV0; m_lock_cnt[0] = LC0;
    m_div[1] = DIV1; m_lock_cnt[1] = LC1;
    $display("[TB] start DIV0=%0d DIV1=%0d", DIV0, DIV1);

    // Reset state.
    do_reset();

    // Ideal input: lock after the first edge plus LOCK_CNT good periods.
    applyStimulus(12 * DIV0);
    checkOutput("ideal_lock_i0", int'(lock0), 1);
    checkOutput("ideal_lock_i1", int'(lock1), 1);

    // One 10-cycle period, then relock.
    addPeriod(0, 5, 5);
    applyStimulus(10 * DIV0);
    checkOutput("relock_i0", int'(lock0), 1);

    // Stall: hold low well past 2*DIV, then resume.
    addPeriod(0, 5, 30);
    addPeriod(1, 2, 12);
    applyStimulus(35 + 8 * DIV0);

    // Boundary: a period of exactly 2*DIV is measured, and 2*DIV+1 stalls.
    addPeriod(0, 5, 13);
    addPeriod(0, 5, 14);
    addPeriod(1, 2, 6);
    addPeriod(1, 2, 7);
    applyStimulus(40 + 6 * DIV0);

    // Bad duty: high time 2 at DIV=9; high times 3 and 1 at DIV=4.
    addPeriod(0, 2, 7);
    addPeriod(1, 3, 1);
    addPeriod(1, 1, 3);
    applyStimulus(6 * DIV0);

    // Randomized periods and high times, mostly legal.
    for (int k = 0; k < 30; k++) begin
      per = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 20)) : DIV0;
      hi  = int'($urandom_range(1, per - 1));
      addPeriod(0, hi, per - hi);
      per = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 10)) : DIV1;
      hi  = int'($urandom_range(1, per - 1));
      addPeriod(1, hi, per - hi);
    end
    n = (wave0.size() > wave1.size()) ? wave0.size() : wave1.size();
    applyStimulus(n);

    // Reset mid-lock at a random point in the period, then relock.
    applyStimulus(10 * DIV0);
    checkOutput("prereset_lock_i0", int'(lock0), 1);
    applyStimulus(int'($urandom_range(1, 8)));
    do_reset();
    applyStimulus(80);
    checkOutput("postreset_lock_i0", int'(lock0), 1);
    checkOutput("postreset_lock_i1", int'(lock1), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
